// File: rtl/ppu_bus_ctrl.sv
// ppu_bus_ctrl: CPU access to the PPU register window, VRAM/palette/OAM
// ports through the v/t address latch, and 256-byte OAM DMA from CPU RAM.
module ppu_bus_ctrl #(
   parameter int VRAM_AW = 11,
   parameter int PAL_AW  = 5,
   parameter int OAM_AW  = 8,
   parameter int INC_BIG = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [15:0]        cpu_addr,
   input  logic [7:0]         cpu_wdata,
   output logic [7:0]         cpu_rdata,
   output logic               cpu_ack,
   output logic               busy,
   input  logic [1:0]         mirror_mode,
   input  logic [7:0]         ppu_status,
   output logic               ppu_status_read,
   output logic [7:0]         ppu_ctrl1,
   output logic [7:0]         ppu_ctrl2,
   output logic [15:0]        ppu_scroll,
   output logic [VRAM_AW-1:0] vram_addr,
   output logic [7:0]         vram_wdata,
   output logic               vram_we,
   output logic               vram_re,
   input  logic [7:0]         vram_rdata,
   output logic [PAL_AW-1:0]  pal_addr,
   output logic [7:0]         pal_wdata,
   output logic               pal_we,
   output logic               pal_re,
   input  logic [7:0]         pal_rdata,
   output logic [OAM_AW-1:0]  oam_addr,
   output logic [7:0]         oam_wdata,
   output logic               oam_we,
   output logic               oam_re,
   input  logic [7:0]         oam_rdata,
   output logic [15:0]        dma_addr,
   output logic               dma_re,
   input  logic [7:0]         dma_rdata
);

   typedef enum logic [2:0] {
      IDLE, REG, MEM_RD, MEM_WR, DMA_RD, DMA_WR, ACK
   } state_t;

   typedef enum logic [1:0] {
      SRC_NONE, SRC_NT, SRC_PAL, SRC_OAM
   } src_t;

   state_t             state;
   src_t               src;
   logic               w, ph, rwe, rhit;
   logic [2:0]         ra;
   logic [7:0]         wd, rbuf, dpage;
   logic [5:0]         t;
   logic [13:0]        v, inc;
   logic [OAM_AW-1:0]  ptr, cnt, cnt_n;
   logic               is_pal, is_nt, win;
   logic [10:0]        nt_full;
   logic [VRAM_AW-1:0] nt_a;
   logic [PAL_AW-1:0]  pal_a;

   assign win    = (cpu_addr[15:13] == 3'b001);
   assign is_pal = (v[13:8] == 6'h3F);
   assign is_nt  = v[13] & ~is_pal;
   assign inc    = ppu_ctrl1[2] ? 14'(INC_BIG) : 14'd1;
   assign cnt_n  = cnt + 1'b1;
   assign nt_a   = VRAM_AW'(nt_full);

   // nametable index only depends on v[11:0], so v-$1000 maps identically
   always_comb begin
      unique case (mirror_mode)
         2'd0:    nt_full = {v[11], v[9:0]};
         2'd1:    nt_full = {v[10], v[9:0]};
         2'd2:    nt_full = {1'b0, v[9:0]};
         default: nt_full = {1'b1, v[9:0]};
      endcase
      pal_a = v[PAL_AW-1:0];
      if (v[1:0] == 2'b00) pal_a[4] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;  src <= SRC_NONE;
         w <= 1'b0;  ph <= 1'b0;  rwe <= 1'b0;  rhit <= 1'b0;
         ra <= '0;  wd <= '0;  rbuf <= '0;  dpage <= '0;
         t <= '0;  v <= '0;  ptr <= '0;  cnt <= '0;
         cpu_rdata <= '0;  cpu_ack <= 1'b0;  busy <= 1'b0;
         ppu_status_read <= 1'b0;
         ppu_ctrl1 <= '0;  ppu_ctrl2 <= '0;  ppu_scroll <= '0;
         vram_addr <= '0;  vram_wdata <= '0;
         vram_we <= 1'b0;  vram_re <= 1'b0;
         pal_addr <= '0;  pal_wdata <= '0;
         pal_we <= 1'b0;  pal_re <= 1'b0;
         oam_addr <= '0;  oam_wdata <= '0;
         oam_we <= 1'b0;  oam_re <= 1'b0;
         dma_addr <= '0;  dma_re <= 1'b0;
      end else begin
         vram_we <= 1'b0;  vram_re <= 1'b0;
         pal_we <= 1'b0;  pal_re <= 1'b0;
         oam_we <= 1'b0;  oam_re <= 1'b0;
         dma_re <= 1'b0;
         cpu_ack <= 1'b0;  ppu_status_read <= 1'b0;
         unique case (state)
            IDLE: if (cpu_req) begin
               busy <= 1'b1;  rwe <= cpu_we;  ra <= cpu_addr[2:0];
               rhit <= win;  wd <= cpu_wdata;  ph <= 1'b0;
               src <= SRC_NONE;
               if (cpu_we && cpu_addr == 16'h4014) begin
                  dpage <= cpu_wdata;  cnt <= '0;
                  dma_addr <= {cpu_wdata, 8'h00};
                  dma_re <= 1'b1;
                  state <= DMA_RD;
               end else if (win && cpu_addr[2:0] == 3'd4) begin
                  oam_addr <= ptr;
                  if (cpu_we) begin
                     oam_we <= 1'b1;  oam_wdata <= cpu_wdata;
                     ptr <= ptr + 1'b1;
                     state <= MEM_WR;
                  end else begin
                     oam_re <= 1'b1;  src <= SRC_OAM;
                     state <= MEM_RD;
                  end
               end else if (win && cpu_addr[2:0] == 3'd7) begin
                  v <= v + inc;
                  vram_addr <= nt_a;  pal_addr <= pal_a;
                  if (cpu_we) begin
                     vram_wdata <= cpu_wdata;  vram_we <= is_nt;
                     pal_wdata <= cpu_wdata;  pal_we <= is_pal;
                     state <= MEM_WR;
                  end else begin
                     // palette reads refill the buffer from the nametable underneath
                     vram_re <= is_nt | is_pal;  pal_re <= is_pal;
                     src <= is_pal ? SRC_PAL : (is_nt ? SRC_NT : SRC_NONE);
                     state <= MEM_RD;
                  end
               end else begin
                  state <= REG;
               end
            end
            REG: begin
               cpu_ack <= 1'b1;  cpu_rdata <= '0;  state <= ACK;
               if (rhit) begin
                  unique case (ra)
                     3'd0: if (rwe) ppu_ctrl1 <= wd; else cpu_rdata <= ppu_ctrl1;
                     3'd1: if (rwe) ppu_ctrl2 <= wd; else cpu_rdata <= ppu_ctrl2;
                     3'd2: if (!rwe) begin
                        cpu_rdata <= ppu_status;  w <= 1'b0;
                        ppu_status_read <= 1'b1;
                     end
                     3'd3: if (rwe) ptr <= OAM_AW'(wd); else cpu_rdata <= 8'(ptr);
                     3'd5: if (rwe) begin
                        if (!w) ppu_scroll[15:8] <= wd;
                        else ppu_scroll[7:0] <= wd;
                        w <= ~w;
                     end
                     3'd6: if (rwe) begin
                        if (!w) t <= wd[5:0];
                        else v <= {t, wd};
                        w <= ~w;
                     end
                     default: ;
                  endcase
               end
            end
            MEM_WR: begin
               cpu_ack <= 1'b1;  state <= ACK;
            end
            MEM_RD: if (!ph) begin
               ph <= 1'b1;
            end else begin
               cpu_ack <= 1'b1;  state <= ACK;
               unique case (src)
                  SRC_NT:  begin cpu_rdata <= rbuf;  rbuf <= vram_rdata; end
                  SRC_PAL: begin cpu_rdata <= pal_rdata;  rbuf <= vram_rdata; end
                  SRC_OAM: cpu_rdata <= oam_rdata;
                  default: begin cpu_rdata <= rbuf;  rbuf <= '0; end
               endcase
            end
            DMA_RD: state <= DMA_WR;
            DMA_WR: begin
               oam_we <= 1'b1;  oam_addr <= ptr + cnt;
               oam_wdata <= dma_rdata;
               if (&cnt) begin
                  rhit <= 1'b0;  state <= REG;
               end else begin
                  cnt <= cnt_n;  dma_addr <= {dpage, 8'(cnt_n)};
                  dma_re <= 1'b1;  state <= DMA_RD;
               end
            end
            ACK: begin
               busy <= 1'b0;  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ppu_bus_ctrl.sv
// Bench for ppu_bus_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the PPU register interface.
module tb_ppu_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack, busy;
   logic [1:0]  mirror_mode = 2'd0;
   logic [7:0]  ppu_status = 8'h00;
   logic        ppu_status_read;
   logic [7:0]  ppu_ctrl1, ppu_ctrl2;
   logic [15:0] ppu_scroll;
   logic [10:0] vram_addr;
   logic [7:0]  vram_wdata, vq;
   logic        vram_we, vram_re;
   logic [4:0]  pal_addr;
   logic [7:0]  pal_wdata, pq;
   logic        pal_we, pal_re;
   logic [7:0]  oam_addr, oam_wdata, oq;
   logic        oam_we, oam_re;
   logic [15:0] dma_addr;
   logic        dma_re;
   logic [7:0]  dq;

   ppu_bus_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_ack(cpu_ack), .busy(busy),
      .mirror_mode(mirror_mode), .ppu_status(ppu_status),
      .ppu_status_read(ppu_status_read),
      .ppu_ctrl1(ppu_ctrl1), .ppu_ctrl2(ppu_ctrl2), .ppu_scroll(ppu_scroll),
      .vram_addr(vram_addr), .vram_wdata(vram_wdata),
      .vram_we(vram_we), .vram_re(vram_re), .vram_rdata(vq),
      .pal_addr(pal_addr), .pal_wdata(pal_wdata),
      .pal_we(pal_we), .pal_re(pal_re), .pal_rdata(pq),
      .oam_addr(oam_addr), .oam_wdata(oam_wdata),
      .oam_we(oam_we), .oam_re(oam_re), .oam_rdata(oq),
      .dma_addr(dma_addr), .dma_re(dma_re), .dma_rdata(dq)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] cram(input logic [15:0] a);
      return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
   endfunction

   // external memories
   logic [7:0]  vmem [0:2047];
   logic [7:0]  pmem [0:31];
   logic [7:0]  omem [0:255];
   logic [10:0] last_vw;
   logic [4:0]  last_pw, last_pr;

   always @(posedge clk) begin
      if (vram_we) begin vmem[vram_addr] <= vram_wdata; last_vw <= vram_addr; end
      if (vram_re) vq <= vmem[vram_addr];
      if (pal_we) begin pmem[pal_addr] <= pal_wdata; last_pw <= pal_addr; end
      if (pal_re) begin pq <= pmem[pal_addr]; last_pr <= pal_addr; end
      if (oam_we) omem[oam_addr] <= oam_wdata;
      if (oam_re) oq <= omem[oam_addr];
      if (dma_re) dq <= cram(dma_addr);
   end

   int checks = 0, errors = 0;

   // reference model state
   logic [7:0]  m_ctrl1, m_ctrl2, m_buf;
   logic [15:0] m_scroll;
   int          m_t, m_v, m_ptr;
   bit          m_w;
   logic [7:0]  nt_sh [0:2047];
   logic [7:0]  pal_sh [0:31];
   logic [7:0]  oam_sh [0:255];

   logic [7:0] e_rd, a_rd;
   int         e_lat, a_lat;
   logic       e_pulse, a_pulse, a_bz;

   function automatic int nt_idx(input int a, input logic [1:0] mode);
      int tbl, pg;
      tbl = (a >> 10) & 3;
      case (mode)
         2'd0: pg = tbl / 2;
         2'd1: pg = tbl % 2;
         2'd2: pg = 0;
         default: pg = 1;
      endcase
      return pg * 1024 + (a & 1023);
   endfunction

   function automatic int pal_idx(input int a);
      int i;
      i = a % 32;
      if (i >= 16 && i % 4 == 0) i -= 16;
      return i;
   endfunction

   task automatic model_reset();
      m_ctrl1 = 0; m_ctrl2 = 0; m_buf = 0; m_scroll = 0;
      m_t = 0; m_v = 0; m_ptr = 0; m_w = 0;
   endtask

   task automatic model_access(input logic we, input logic [15:0] addr,
                               input logic [7:0] wd);
      int r, va;
      e_rd = 0; e_lat = 1; e_pulse = 0;
      if (we && addr == 16'h4014) begin
         for (int i = 0; i < 256; i++)
            oam_sh[(m_ptr + i) % 256] = cram(16'(wd * 256 + i));
         e_lat = 513;
      end else if (addr >= 16'h2000 && addr < 16'h4000) begin
         r = addr % 8;
         case (r)
            0: if (we) m_ctrl1 = wd; else e_rd = m_ctrl1;
            1: if (we) m_ctrl2 = wd; else e_rd = m_ctrl2;
            2: if (!we) begin e_rd = ppu_status; m_w = 0; e_pulse = 1; end
            3: if (we) m_ptr = wd; else e_rd = 8'(m_ptr);
            4: if (we) begin
                  oam_sh[m_ptr] = wd; m_ptr = (m_ptr + 1) % 256;
               end else begin
                  e_rd = oam_sh[m_ptr]; e_lat = 2;
               end
            5: if (we) begin
                  if (!m_w) m_scroll[15:8] = wd; else m_scroll[7:0] = wd;
                  m_w = !m_w;
               end
            6: if (we) begin
                  if (!m_w) m_t = wd % 64; else m_v = m_t * 256 + wd;
                  m_w = !m_w;
               end
            default: begin
               va = m_v;
               if (we) begin
                  if (va >= 'h3F00) pal_sh[pal_idx(va)] = wd;
                  else if (va >= 'h2000) nt_sh[nt_idx(va, mirror_mode)] = wd;
               end else begin
                  e_lat = 2;
                  if (va >= 'h3F00) begin
                     e_rd = pal_sh[pal_idx(va)];
                     m_buf = nt_sh[nt_idx(va - 'h1000, mirror_mode)];
                  end else begin
                     e_rd = m_buf;
                     m_buf = (va >= 'h2000) ? nt_sh[nt_idx(va, mirror_mode)] : 8'h00;
                  end
               end
               m_v = (m_v + (m_ctrl1[2] ? 32 : 1)) % 16384;
            end
         endcase
      end
   endtask

   task automatic do_access(input logic we, input logic [15:0] addr,
                            input logic [7:0] wd);
      int g;
      g = 0;
      while (busy !== 1'b0 && g < 2000) begin @(posedge clk); #1; g++; end
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      a_lat = 0; a_rd = 8'hxx; a_pulse = 1'b0; a_bz = 1'b1;
      for (int k = 1; k <= 2000; k++) begin
         if (busy !== 1'b1) a_bz = 1'b0;
         @(posedge clk); #1;
         if (cpu_ack === 1'b1) begin
            a_lat = k; a_rd = cpu_rdata; a_pulse = ppu_status_read;
            if (busy !== 1'b1) a_bz = 1'b0;
            break;
         end
      end
   endtask

   task automatic op(input logic we, input logic [15:0] addr, input logic [7:0] wd);
      model_access(we, addr, wd);
      do_access(we, addr, wd);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      checks++;
      if ({cpu_ack, busy, ppu_status_read} !== 3'b000) begin
         errors++; $display("FAIL reset_ctl: got %b want 000", {cpu_ack, busy, ppu_status_read});
      end
      checks++;
      if ({ppu_ctrl1, ppu_ctrl2, ppu_scroll, cpu_rdata} !== 40'h0) begin
         errors++; $display("FAIL reset_regs: got %h want 0", {ppu_ctrl1, ppu_ctrl2, ppu_scroll, cpu_rdata});
      end
      checks++;
      if ({vram_we, vram_re, pal_we, pal_re, oam_we, oam_re, dma_re} !== 7'h0) begin
         errors++; $display("FAIL reset_strobes: got %b want 0",
            {vram_we, vram_re, pal_we, pal_re, oam_we, oam_re, dma_re});
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_vram_rw();
      mirror_mode = 2'd0;
      op(1, 16'h2006, 8'h21);
      op(1, 16'h2006, 8'h08);
      checks++;
      if (a_lat !== 1) begin errors++; $display("FAIL reg_lat: got %0d want 1", a_lat); end
      op(1, 16'h2007, 8'h5A);
      checks++;
      if (last_vw !== 11'(nt_idx('h2108, 2'd0))) begin
         errors++; $display("FAIL nt_wr_addr: got %h want %h", last_vw, 11'(nt_idx('h2108, 2'd0)));
      end
      op(1, 16'h2006, 8'h21);
      op(1, 16'h2006, 8'h08);
      op(0, 16'h2007, 8'h00);
      checks++;
      if (a_rd !== e_rd || a_lat !== 2) begin
         errors++; $display("FAIL buf_rd1: got %h/%0d want %h/2", a_rd, a_lat, e_rd);
      end
      op(0, 16'h2007, 8'h00);
      checks++;
      if (a_rd !== e_rd || e_rd !== 8'h5A) begin
         errors++; $display("FAIL buf_rd2: got %h want %h", a_rd, e_rd);
      end
   endtask

   task automatic test_increment();
      int exp_a[4] = '{'h000, 'h020, 'h040, 'h060};
      op(1, 16'h2000, 8'h04);
      op(1, 16'h2006, 8'h20);
      op(1, 16'h2006, 8'h00);
      for (int i = 0; i < 4; i++) begin
         op(1, 16'h2007, 8'(8'h30 + i));
         checks++;
         if (last_vw !== 11'(exp_a[i])) begin
            errors++; $display("FAIL inc32_%0d: got %h want %h", i, last_vw, 11'(exp_a[i]));
         end
      end
      op(1, 16'h2000, 8'h00);
   endtask

   task automatic test_status();
      op(1, 16'h2006, 8'h25);
      ppu_status = 8'($urandom);
      op(0, 16'h2002, 8'h00);
      checks++;
      if (a_rd !== ppu_status || a_pulse !== 1'b1 || a_lat !== 1) begin
         errors++; $display("FAIL status_rd: got %h/%b/%0d want %h/1/1", a_rd, a_pulse, a_lat, ppu_status);
      end
      op(1, 16'h2006, 8'h23);
      op(1, 16'h2006, 8'h45);
      op(1, 16'h2007, 8'h77);
      checks++;
      if (last_vw !== 11'(nt_idx('h2345, 2'd0))) begin
         errors++; $display("FAIL w_clear: got %h want %h", last_vw, 11'(nt_idx('h2345, 2'd0)));
      end
   endtask

   task automatic test_palette();
      op(1, 16'h2006, 8'h3F);
      op(1, 16'h2006, 8'h10);
      op(1, 16'h2007, 8'h0F);
      checks++;
      if (last_pw !== 5'h00) begin errors++; $display("FAIL pal_wr_addr: got %h want 00", last_pw); end
      op(1, 16'h2006, 8'h3F);
      op(1, 16'h2006, 8'h00);
      op(0, 16'h2007, 8'h00);
      checks++;
      if (a_rd !== e_rd || e_rd !== 8'h0F || a_lat !== 2) begin
         errors++; $display("FAIL pal_rd: got %h/%0d want %h/2", a_rd, a_lat, e_rd);
      end
      checks++;
      if (last_pr !== 5'h00) begin errors++; $display("FAIL pal_rd_addr: got %h want 00", last_pr); end
   endtask

   task automatic test_dma();
      int bad;
      op(1, 16'h2003, 8'hFE);
      op(1, 16'h4014, 8'h02);
      checks++;
      if (a_lat !== 513) begin errors++; $display("FAIL dma_lat: got %0d want 513", a_lat); end
      checks++;
      if (a_bz !== 1'b1) begin errors++; $display("FAIL dma_busy: got %b want 1", a_bz); end
      bad = 0;
      for (int i = 0; i < 256; i++) if (omem[i] !== oam_sh[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL dma_oam: got %0d bad bytes want 0", bad); end
      op(0, 16'h2003, 8'h00);
      checks++;
      if (a_rd !== e_rd || e_rd !== 8'hFE) begin
         errors++; $display("FAIL dma_ptr: got %h want %h", a_rd, e_rd);
      end
   endtask

   task automatic test_random();
      logic        we;
      logic [15:0] a;
      logic [7:0]  d;
      int          kind, bad;
      for (int n = 0; n < 300; n++) begin
         mirror_mode = 2'($urandom_range(0, 3));
         ppu_status = 8'($urandom);
         kind = $urandom_range(0, 11);
         d = 8'($urandom);
         a = 16'h2000 | (16'($urandom) & 16'h1FF8);
         we = 1'b1;
         if ((kind >= 5 && kind <= 8) && m_v < 'h2000) kind = 4;
         case (kind)
            0: a |= 16'd0;
            1: a |= 16'd1;
            2: begin we = 1'b0; a |= 16'($urandom_range(0, 1)); end
            3: a |= 16'd5;
            4: begin a |= 16'd6; if (!m_w) d |= 8'h20; end
            5, 6: a |= 16'd7;
            7, 8: begin we = 1'b0; a |= 16'd7; end
            9: begin
               we = 1'($urandom_range(0, 1));
               a |= 16'($urandom_range(3, 4));
            end
            10: begin we = 1'b0; a |= 16'd2; end
            default: begin
               we = 1'($urandom_range(0, 1));
               a = 16'($urandom);
               if (a[15:13] == 3'b001 || a == 16'h4014) a = 16'h4015;
            end
         endcase
         op(we, a, d);
         checks++;
         if (a_lat !== e_lat) begin
            errors++; $display("FAIL rand_lat: op %0d addr %h got %0d want %0d", n, a, a_lat, e_lat);
         end
         if (!we) begin
            checks++;
            if (a_rd !== e_rd) begin
               errors++; $display("FAIL rand_rd: op %0d addr %h got %h want %h", n, a, a_rd, e_rd);
            end
         end
         checks++;
         if (a_pulse !== e_pulse) begin
            errors++; $display("FAIL rand_pulse: op %0d got %b want %b", n, a_pulse, e_pulse);
         end
         checks++;
         if ({ppu_ctrl1, ppu_ctrl2, ppu_scroll} !== {m_ctrl1, m_ctrl2, m_scroll}) begin
            errors++; $display("FAIL rand_regs: op %0d got %h want %h", n,
               {ppu_ctrl1, ppu_ctrl2, ppu_scroll}, {m_ctrl1, m_ctrl2, m_scroll});
         end
      end
      bad = 0;
      for (int i = 0; i < 2048; i++) if (vmem[i] !== nt_sh[i]) bad++;
      for (int i = 0; i < 32; i++) if (pmem[i] !== pal_sh[i]) bad++;
      for (int i = 0; i < 256; i++) if (omem[i] !== oam_sh[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rand_mem: got %0d bad bytes want 0", bad); end
   endtask

   task automatic test_dma_reset();
      int acks, g;
      op(1, 16'h2000, 8'hA5);
      g = 0;
      while (busy !== 1'b0 && g < 2000) begin @(posedge clk); #1; g++; end
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h03;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      acks = 0;
      repeat (80) begin @(posedge clk); #1; if (cpu_ack === 1'b1) acks++; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      checks++;
      if (acks != 0 || cpu_ack !== 1'b0) begin
         errors++; $display("FAIL rst_noack: got %0d acks want 0", acks);
      end
      checks++;
      if ({oam_we, dma_re, busy, vram_we, pal_we} !== 5'b0) begin
         errors++; $display("FAIL rst_strobes: got %b want 0", {oam_we, dma_re, busy, vram_we, pal_we});
      end
      checks++;
      if ({ppu_ctrl1, ppu_ctrl2, ppu_scroll, dma_addr} !== 48'h0) begin
         errors++; $display("FAIL rst_regs: got %h want 0", {ppu_ctrl1, ppu_ctrl2, ppu_scroll, dma_addr});
      end
      op(1, 16'h2001, 8'h3C);
      checks++;
      if (a_lat !== 1 || ppu_ctrl2 !== 8'h3C) begin
         errors++; $display("FAIL post_rst_wr: got %0d/%h want 1/3c", a_lat, ppu_ctrl2);
      end
      op(0, 16'h2001, 8'h00);
      checks++;
      if (a_rd !== e_rd) begin errors++; $display("FAIL post_rst_rd: got %h want %h", a_rd, e_rd); end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) begin vmem[i] = 0; nt_sh[i] = 0; end
      for (int i = 0; i < 32; i++) begin pmem[i] = 0; pal_sh[i] = 0; end
      for (int i = 0; i < 256; i++) begin omem[i] = 0; oam_sh[i] = 0; end
      test_reset();
      test_vram_rw();
      test_increment();
      test_status();
      test_palette();
      test_dma();
      test_random();
      test_dma_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ppu_bus_ctrl.md
Name: ppu_bus_ctrl

Overview:
Parametrised successor to the PPU/CPU memory controller. Decodes CPU accesses to the PPU register window ($2000-$3FFF, mirrored every 8 bytes) and $4014. Implements the two-write address latch, the buffered $2007 read, nametable mirroring, and OAM DMA. Sits between the CPU bus arbiter and the synchronous VRAM, OAM and CPU-RAM blocks; memories are external, one-cycle-latency RAM ports.

Parameters:
VRAM_AW, 11, physical nametable RAM address width (2 KB default).
PAL_AW, 5, palette RAM address width.
OAM_AW, 8, OAM address width; DMA length = 2**OAM_AW bytes.
INC_BIG, 32, VRAM increment when ctrl1[2]=1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cpu_req  in  1  access request; accepted when cpu_req=1 and busy=0
cpu_we  in  1  1=write, 0=read; sampled on accept
cpu_addr  in  16  CPU address; sampled on accept
cpu_wdata  in  8  write data; sampled on accept
cpu_rdata  out  8  read data, valid while cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
busy  out  1  high from accept through the ack cycle, and during DMA
mirror_mode  in  2  0=horizontal, 1=vertical, 2=single-A, 3=single-B
ppu_status  in  8  status byte from PPU core
ppu_status_read  out  1  one-cycle pulse on $2002 read
ppu_ctrl1  out  8  $2000 register
ppu_ctrl2  out  8  $2001 register
ppu_scroll  out  16  {first,second} $2005 writes
vram_addr/vram_wdata/vram_we/vram_re  out  VRAM_AW/8/1/1  nametable RAM port
vram_rdata  in  8  valid the cycle after vram_re
pal_addr/pal_wdata/pal_we/pal_re  out  PAL_AW/8/1/1  palette RAM port
pal_rdata  in  8  valid the cycle after pal_re
oam_addr/oam_wdata/oam_we/oam_re  out  OAM_AW/8/1/1  OAM port
oam_rdata  in  8  valid the cycle after oam_re
dma_addr  out  16  CPU-RAM read address for DMA
dma_re  out  1  CPU-RAM read strobe
dma_rdata  in  8  valid the cycle after dma_re

Behaviour:
- Reset: all outputs 0, state IDLE, write toggle w=0, v=0, read buffer=0, oam pointer=0, all strobes low.
- Decode: reg = cpu_addr[2:0] when cpu_addr[15:13]=3'b001; $4014 = DMA; any other address -> ack next cycle, rdata=0, no side effects.
- States: IDLE, REG (one-cycle register op), MEM_RD (wait for RAM data), MEM_WR, DMA_RD, DMA_WR, ACK.
- Register accesses ($2000-$2003, $2005, $2006) ack the cycle after accept. Reads of $2000/$2001/$2003 return the register; writes to $2002 are ignored.
- $2002 read: rdata=ppu_status, w<=0, ppu_status_read pulses with cpu_ack.
- $2005 write: w=0 -> scroll[15:8]; w=1 -> scroll[7:0]; w toggles. $2006 write: w=0 -> t[13:8]<=wdata[5:0]; w=1 -> v<={t[13:8],wdata}; w toggles. $2005 and $2006 share w.
- $2004 write: oam[ptr]<=wdata, ptr+1 (wraps at 2**OAM_AW). $2004 read: oam_re, ack with oam_rdata, ptr unchanged.
- Address map for v (14 bits): <$2000 -> no RAM (read 0, write dropped); $2000-$3EFF -> nametable via mirror_mode (H: {v[11],v[9:0]}; V: {v[10],v[9:0]}; single-A/B: {0/1,v[9:0]}), truncated/zero-extended to VRAM_AW; $3F00-$3FFF -> palette v[PAL_AW-1:0], with $3F10/14/18/1C aliased to $3F00/04/08/0C.
- $2007 write: RAM write on mapped target, ack next cycle. $2007 read (nametable): rdata=old buffer, buffer<=RAM data. $2007 read (palette): rdata=palette data directly; buffer<=nametable data at v-$1000. Read latency = 2 cycles accept->ack.
- After every $2007 access, v<=(v + (ctrl1[2]?INC_BIG:1)) mod 2**14.
- DMA: write of N to $4014 -> for i=0..2**OAM_AW-1: DMA_RD (dma_addr={N,i[7:0]}, dma_re), DMA_WR (oam[ptr+i]<=dma_rdata). 2 cycles/byte; ack after last write; ptr unchanged at end (wraps through full circle). busy high throughout; cpu_req ignored until busy=0.
- Simultaneous: mirror_mode change takes effect on the next mapping computation; ppu_status sampled in the REG cycle.
- rst mid-access or mid-DMA: abort immediately, no ack, all strobes low next cycle, state IDLE.

Test Plan:
- Write $2006=$21,$08, write $2007=$5A, read $2007 twice -> first rdata=prior buffer (0 after reset), second=$5A; v=$210A; vram_addr for the write=$108 (H mirror).
- Write ctrl1=$04, set v=$2000, 3x $2007 write -> vram writes at $000,$020,$040; v=$2060.
- Write $2006 once, read $2002 -> ppu_status_read pulses, w=0; next $2006 write lands in t[13:8].
- Palette: write $3F10=$0F, read $3F00 -> rdata=$0F immediately, pal_addr=$00 on both.
- oam ptr=$FE, write $4014=$02 -> 256 writes oam[$FE],$FF,$00..$FD from $0200-$02FF; ack at 513 cycles after accept; busy high throughout.
- Assert rst at DMA byte 40 -> no ack, oam_we low next cycle, all outputs 0, next request serviced normally.
